// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// The op-code values must agree with the ALU sitting behind the scheduler.
package alu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   localparam int unsigned DEF_N_REQ = 2;
   localparam int unsigned DEF_XLEN  = 32;
   localparam int unsigned DEF_OPW   = 4;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins; returns a one-hot grant and its index.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]                       req,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
   output logic [N-1:0]                       gnt,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx,
   output logic                               gnt_valid
);
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

   logic [IW-1:0] k;

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      k         = '0;
      for (int unsigned i = 0; i < N; i++) begin
         k = IW'((32'(ptr) + i) % N);
         if (!gnt_valid && req[k]) begin
            gnt_valid = 1'b1;
            gnt[k]    = 1'b1;
            gnt_idx   = k;
         end
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Time-shares one ALU between N_REQ requesters with round-robin arbitration;
// one operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (deliver).
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int unsigned N_REQ = DEF_N_REQ,
   parameter int unsigned XLEN  = DEF_XLEN,
   parameter int unsigned OPW   = DEF_OPW
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req_valid_i,
   output logic [N_REQ-1:0]           req_ready_o,
   input  logic [N_REQ-1:0][XLEN-1:0] req_a_i,
   input  logic [N_REQ-1:0][XLEN-1:0] req_b_i,
   input  logic [N_REQ-1:0][OPW-1:0]  req_op_i,
   output logic [XLEN-1:0]            alu_a_o,
   output logic [XLEN-1:0]            alu_b_o,
   output logic [OPW-1:0]             alu_op_o,
   input  logic [XLEN-1:0]            alu_result_i,
   input  logic                       alu_zero_i,
   output logic [N_REQ-1:0]           rsp_valid_o,
   input  logic [N_REQ-1:0]           rsp_ready_i,
   output logic [XLEN-1:0]            rsp_result_o,
   output logic                       rsp_zero_o
);
   localparam int unsigned      IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE  = N_REQ'(1);
   localparam logic [IW-1:0]    LAST = IW'(N_REQ - 1);

   state_e           state_q;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    owner_q;
   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_valid;

   rr_arbiter #(
      .N (N_REQ)
   ) u_arb (
      .req       (req_valid_i),
      .ptr       (ptr_q),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // Ready is masked during reset so nothing can be accepted while state is forced.
   always_comb begin
      req_ready_o = '0;
      if (state_q == IDLE && !reset) begin
         req_ready_o = gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         alu_a_o      <= '0;
         alu_b_o      <= '0;
         alu_op_o     <= '0;
         rsp_valid_o  <= '0;
         rsp_result_o <= '0;
         rsp_zero_o   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  alu_a_o  <= req_a_i[gnt_idx];
                  alu_b_o  <= req_b_i[gnt_idx];
                  alu_op_o <= req_op_i[gnt_idx];
                  owner_q  <= gnt_idx;
                  ptr_q    <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
                  state_q  <= EXEC;
               end
            end
            EXEC: begin
               rsp_result_o <= alu_result_i;
               rsp_zero_o   <= alu_zero_i;
               rsp_valid_o  <= ONE << owner_q;
               state_q      <= RESP;
            end
            RESP: begin
               // Only the owner's ready can retire the response.
               if (rsp_ready_i[owner_q]) begin
                  rsp_valid_o <= '0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               rsp_valid_o <= '0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler with three requesters: directed cases plus random
// traffic checked against a transaction-level round-robin reference model.
module tb_alu_rr_scheduler;
   import alu_sched_pkg::*;

   localparam int unsigned N = 3;

   logic             clk;
   logic             reset;
   logic [N-1:0]       req_valid_i;
   logic [N-1:0]       req_ready_o;
   logic [N-1:0][31:0] req_a_i;
   logic [N-1:0][31:0] req_b_i;
   logic [N-1:0][3:0]  req_op_i;
   logic [31:0]        alu_a_o;
   logic [31:0]        alu_b_o;
   logic [3:0]         alu_op_o;
   logic [31:0]        alu_result;
   logic               alu_zero;
   logic [N-1:0]       rsp_valid_o;
   logic [N-1:0]       rsp_ready_i;
   logic [31:0]        rsp_result_o;
   logic               rsp_zero_o;

   int n_checks = 0;
   int n_fail   = 0;
   int mptr     = 0;

   logic [31:0] ra [N];
   logic [31:0] rb [N];
   logic [3:0]  rop[N];

   alu_rr_scheduler #(
      .N_REQ (N),
      .XLEN  (32),
      .OPW   (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .req_op_i     (req_op_i),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_op_o     (alu_op_o),
      .alu_result_i (alu_result),
      .alu_zero_i   (alu_zero),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_result_o (rsp_result_o),
      .rsp_zero_o   (rsp_zero_o)
   );

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
      case (op)
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_XOR: return a ^ b;
         ALU_SLL: return a << b[4:0];
         ALU_SRL: return a >> b[4:0];
         ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
         default: return 32'h0;
      endcase
   endfunction

   // Stand-in for the combinational ALU behind the scheduler.
   assign alu_result = alu_fn(alu_a_o, alu_b_o, alu_op_o);
   assign alu_zero   = (alu_result == 32'h0);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pick(input logic [N-1:0] v, input int p);
      logic [N-1:0] t;
      for (int i = 0; i < int'(N); i++) begin
         t = v >> ((p + i) % int'(N));
         if (t[0]) return (p + i) % int'(N);
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Entered and left ~1ns after a negedge in an IDLE cycle.
   task automatic run_op(input logic [N-1:0] v, input logic [N-1:0] busy, input int hold);
      int           g;
      logic [N-1:0] oh;
      logic [31:0]  er;
      logic         ez;
      for (int k = 0; k < int'(N); k++) begin
         req_a_i[k]  = ra[k];
         req_b_i[k]  = rb[k];
         req_op_i[k] = rop[k];
      end
      req_valid_i = v;
      g  = pick(v, mptr);
      oh = N'(1) << g;
      er = alu_fn(ra[g], rb[g], rop[g]);
      ez = (er == 32'h0);
      mptr = (g + 1) % int'(N);
      #1;
      chk("grant", 32'(req_ready_o), 32'(oh));

      @(negedge clk);
      req_valid_i = busy;
      #1;
      chk("exec_ready", 32'(req_ready_o), 32'h0);
      chk("exec_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("alu_a", alu_a_o, ra[g]);
      chk("alu_b", alu_b_o, rb[g]);
      chk("alu_op", 32'(alu_op_o), 32'(rop[g]));

      step();
      chk("rsp_valid", 32'(rsp_valid_o), 32'(oh));
      chk("rsp_result", rsp_result_o, er);
      chk("rsp_zero", 32'(rsp_zero_o), 32'(ez));
      chk("resp_ready", 32'(req_ready_o), 32'h0);
      for (int h = 0; h < hold; h++) begin
         rsp_ready_i = N'($urandom) & ~oh;
         step();
         chk("rsp_hold_valid", 32'(rsp_valid_o), 32'(oh));
         chk("rsp_hold_result", rsp_result_o, er);
         chk("rsp_hold_ready", 32'(req_ready_o), 32'h0);
      end
      rsp_ready_i = oh;
      step();
      rsp_ready_i = '0;
      chk("rsp_clear", 32'(rsp_valid_o), 32'h0);
   endtask

   initial begin
      reset       = 1'b1;
      req_valid_i = '1;
      rsp_ready_i = '0;
      req_a_i     = '0;
      req_b_i     = '0;
      req_op_i    = '0;
      for (int k = 0; k < int'(N); k++) begin
         ra[k] = 32'h0; rb[k] = 32'h0; rop[k] = ALU_ADD;
      end

      step();
      step();
      chk("reset_ready", 32'(req_ready_o), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("reset_result", rsp_result_o, 32'h0);
      chk("reset_zero", 32'(rsp_zero_o), 32'h0);
      chk("reset_alu_a", alu_a_o, 32'h0);
      chk("reset_alu_op", 32'(alu_op_o), 32'h0);
      req_valid_i = '0;
      reset = 1'b0;
      step();
      mptr = 0;

      // req0: 5 + 7
      ra[0] = 32'd5; rb[0] = 32'd7; rop[0] = ALU_ADD;
      run_op(3'b001, 3'b000, 0);
      chk("add_result_value", rsp_result_o, 32'd12);

      // req1: 9 - 9, response held for 4 cycles while others wait
      ra[1] = 32'd9; rb[1] = 32'd9; rop[1] = ALU_SUB;
      run_op(3'b010, 3'b101, 4);
      chk("sub_zero_flag", 32'(rsp_zero_o), 32'h1);

      // Reset while the accepted op is in EXEC.
      ra[1] = 32'hdead_beef; rb[1] = 32'h1; rop[1] = ALU_ADD;
      req_valid_i = 3'b010;
      #1;
      chk("rst_grant", 32'(req_ready_o), 32'(N'(1) << pick(3'b010, mptr)));
      @(negedge clk);
      reset = 1'b1;
      req_valid_i = '0;
      step();
      reset = 1'b0;
      chk("midrst_alu_a", alu_a_o, 32'h0);
      chk("midrst_alu_b", alu_b_o, 32'h0);
      chk("midrst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      chk("midrst_result", rsp_result_o, 32'h0);
      mptr = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("midrst_no_rsp", 32'(rsp_valid_o), 32'h0);
      end

      // All valid continuously: strict rotation 0,1,2,0,1,2.
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < int'(N); k++) begin
            ra[k] = 32'(100 * k + i); rb[k] = 32'(k + 1); rop[k] = ALU_ADD;
         end
         run_op(3'b111, 3'b111, i % 2);
      end

      // req0 waits while req1 is served, then withdraws; req2 gets the next grant.
      mptr = pick(3'b010, mptr) == 1 ? mptr : mptr;
      run_op(3'b110, 3'b001, 2);
      run_op(3'b100, 3'b000, 1);

      // Random traffic.
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < int'(N); k++) begin
            ra[k]  = $urandom;
            rb[k]  = ($urandom_range(0, 3) == 0) ? ra[k] : $urandom;
            rop[k] = 4'($urandom_range(0, 7));
         end
         run_op(N'($urandom_range(1, 7)), N'($urandom), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
